// File: rtl/gci_std_display_pkg.sv
// ---------------------------------------------------------------------------
// gci_std_display_pkg
// Shared constants and types for the gci_std_display character pipeline.
//   FONT_W / FONT_H  : glyph cell size in pixels (8 x 14)
//   FONT_BITS        : packed glyph width (row 0 in the MSBs, MSB = leftmost)
//   FONT_OFFSET      : first ASCII code held in the font ROM
//   state_t          : character renderer sequencer states
// ---------------------------------------------------------------------------
package gci_std_display_pkg;

    localparam int         FONT_W      = 8;
    localparam int         FONT_H      = 14;
    localparam int         FONT_BITS   = 112;
    localparam logic [6:0] FONT_OFFSET = 7'h20;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAW
    } state_t;

endpackage

// File: rtl/gci_std_display_font.sv
// ---------------------------------------------------------------------------
// gci_std_display_font
// Combinational 8x14 font ROM. Glyph index = ASCII code - 0x20.
//   iADDR [6:0]   : glyph index; indices >= 94 return an all-zero glyph
//   oDATA [111:0] : packed glyph, row 0 in bits [111:104], MSB = leftmost
// Glyphs not populated below render blank.
// ---------------------------------------------------------------------------
module gci_std_display_font
    import gci_std_display_pkg::*;
(
    input  logic [6:0]           iADDR,
    output logic [FONT_BITS-1:0] oDATA
);

    always_comb begin
        oDATA = '0;
        case (iADDR)
            7'h0D: oDATA = 112'h00_00_00_00_00_00_00_7E_00_00_00_00_00_00; // '-'
            7'h10: oDATA = 112'h00_00_3C_66_6E_76_66_66_66_3C_00_00_00_00; // '0'
            7'h11: oDATA = 112'h00_00_18_38_18_18_18_18_18_7E_00_00_00_00; // '1'
            7'h21: oDATA = 112'h00_00_18_3C_66_66_7E_66_66_66_66_00_00_00; // 'A'
            7'h22: oDATA = 112'h00_00_7C_66_66_66_7C_66_66_66_7C_00_00_00; // 'B'
            default: oDATA = '0;
        endcase
    end

endmodule

// File: rtl/gci_std_display_char_renderer.sv
// ---------------------------------------------------------------------------
// gci_std_display_char_renderer
// Renders one 8x14 character cell into VRAM, one pixel write per glyph pixel.
//   iCLOCK, iRESET_SYNC        : clock, synchronous active-high reset
//   iIF_REQ / oIF_BUSY         : command handshake (accept = REQ && !BUSY)
//   iIF_CHAR/CX/CY/FG/BG       : ASCII code, cell column/row, colours
//   oIF_DONE / oIF_ERR         : one-cycle completion / drop pulses
//   oVRAM_REQ / iVRAM_BUSY     : pixel write valid / backpressure
//   oVRAM_ADDR / oVRAM_DATA    : linear pixel address / colour
// Build option GCI_STD_DISPLAY_CHAR_TRANSPARENT_EN: background pixels are
// skipped (no write, one cycle each) and iIF_BG is unused.
// ---------------------------------------------------------------------------
module gci_std_display_char_renderer
    import gci_std_display_pkg::*;
#(
    parameter int P_H_WIDTH = 640,
    parameter int P_H_CHARS = 80,
    parameter int P_V_CHARS = 34,
    parameter int P_ADDR_W  = 19,
    parameter int P_COLOR_W = 16
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET_SYNC,
    input  logic                 iIF_REQ,
    output logic                 oIF_BUSY,
    input  logic [6:0]           iIF_CHAR,
    input  logic [6:0]           iIF_CX,
    input  logic [5:0]           iIF_CY,
    input  logic [P_COLOR_W-1:0] iIF_FG,
    input  logic [P_COLOR_W-1:0] iIF_BG,
    output logic                 oIF_DONE,
    output logic                 oIF_ERR,
    output logic                 oVRAM_REQ,
    input  logic                 iVRAM_BUSY,
    output logic [P_ADDR_W-1:0]  oVRAM_ADDR,
    output logic [P_COLOR_W-1:0] oVRAM_DATA
);

    localparam logic [6:0]          H_CHARS    = 7'(P_H_CHARS);
    localparam logic [5:0]          V_CHARS    = 6'(P_V_CHARS);
    localparam logic [P_ADDR_W-1:0] ROW_PITCH  = P_ADDR_W'(P_H_WIDTH);
    localparam logic [P_ADDR_W-1:0] CELL_PITCH = P_ADDR_W'(FONT_H * P_H_WIDTH);
    localparam logic [P_ADDR_W-1:0] CELL_W     = P_ADDR_W'(FONT_W);

    state_t                 state, state_next;
    logic [6:0]             char_q;
    logic [6:0]             cx_q;
    logic [5:0]             cy_q;
    logic [P_COLOR_W-1:0]   fg_q;
`ifndef GCI_STD_DISPLAY_CHAR_TRANSPARENT_EN
    logic [P_COLOR_W-1:0]   bg_q;
`endif
    logic [FONT_BITS-1:0]   glyph_q;
    logic [FONT_BITS-1:0]   font_data;
    logic [6:0]             font_addr;
    logic [P_ADDR_W-1:0]    row_base_q;
    logic [P_ADDR_W-1:0]    base_addr;
    logic [3:0]             row_q;
    logic [2:0]             col_q;
    logic [6:0]             pix_idx;
    logic                   pix_bit;
    logic                   pix_adv;
    logic                   last_pix;
    logic                   accept;
    logic                   cmd_ok;
    logic                   done_q;
    logic                   err_q;

    // Out-of-range codes wrap in the 7-bit subtract and land past the ROM.
    assign font_addr = char_q - FONT_OFFSET;

    gci_std_display_font u_font (
        .iADDR (font_addr),
        .oDATA (font_data)
    );

    assign accept    = iIF_REQ && (state == IDLE);
    assign cmd_ok    = (iIF_CX < H_CHARS) && (iIF_CY < V_CHARS);
    assign base_addr = P_ADDR_W'(cy_q) * CELL_PITCH + P_ADDR_W'(cx_q) * CELL_W;
    // {row,col} is row*8+col, the raster index of the current pixel.
    assign pix_idx   = 7'(FONT_BITS - 1) - {row_q, col_q};
    assign pix_bit   = glyph_q[pix_idx];
    assign last_pix  = (row_q == 4'(FONT_H - 1)) && (col_q == 3'(FONT_W - 1));
    assign oIF_DONE  = done_q;
    assign oIF_ERR   = err_q;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) state <= IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        oIF_BUSY   = 1'b0;
        oVRAM_REQ  = 1'b0;
        oVRAM_ADDR = '0;
        oVRAM_DATA = '0;
        pix_adv    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && cmd_ok) state_next = LOAD;
            end
            LOAD: begin
                oIF_BUSY   = 1'b1;
                state_next = DRAW;
            end
            DRAW: begin
                oIF_BUSY   = 1'b1;
                oVRAM_ADDR = row_base_q + P_ADDR_W'(col_q);
`ifdef GCI_STD_DISPLAY_CHAR_TRANSPARENT_EN
                oVRAM_REQ  = pix_bit;
                oVRAM_DATA = fg_q;
                pix_adv    = !pix_bit || !iVRAM_BUSY;
`else
                oVRAM_REQ  = 1'b1;
                oVRAM_DATA = pix_bit ? fg_q : bg_q;
                pix_adv    = !iVRAM_BUSY;
`endif
                if (pix_adv && last_pix) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            char_q     <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            fg_q       <= '0;
`ifndef GCI_STD_DISPLAY_CHAR_TRANSPARENT_EN
            bg_q       <= '0;
`endif
            glyph_q    <= '0;
            row_base_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (cmd_ok) begin
                            char_q <= iIF_CHAR;
                            cx_q   <= iIF_CX;
                            cy_q   <= iIF_CY;
                            fg_q   <= iIF_FG;
`ifndef GCI_STD_DISPLAY_CHAR_TRANSPARENT_EN
                            bg_q   <= iIF_BG;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    glyph_q    <= font_data;
                    row_base_q <= base_addr;
                    row_q      <= '0;
                    col_q      <= '0;
                end
                DRAW: begin
                    if (pix_adv) begin
                        col_q <= col_q + 3'd1;
                        if (col_q == 3'(FONT_W - 1)) begin
                            row_q      <= row_q + 4'd1;
                            row_base_q <= row_base_q + ROW_PITCH;
                        end
                        if (last_pix) done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gci_std_display_char_renderer.sv
// ---------------------------------------------------------------------------
// tb_gci_std_display_char_renderer
// Self-checking bench for gci_std_display_char_renderer. Expected pixel
// writes come from a per-row font table and the cell address arithmetic;
// a negedge monitor compares every accepted write and every stall.
// Honours GCI_STD_DISPLAY_CHAR_TRANSPARENT_EN like the design.
// ---------------------------------------------------------------------------
module tb_gci_std_display_char_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        busy;
    logic [6:0]  ch;
    logic [6:0]  cx;
    logic [5:0]  cy;
    logic [15:0] fg;
    logic [15:0] bg;
    logic        done;
    logic        err;
    logic        vreq;
    logic        vbusy;
    logic [18:0] vaddr;
    logic [15:0] vdata;

`ifdef GCI_STD_DISPLAY_CHAR_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    always #5 clk = ~clk;

    gci_std_display_char_renderer #(
        .P_H_WIDTH (640),
        .P_H_CHARS (80),
        .P_V_CHARS (34),
        .P_ADDR_W  (19),
        .P_COLOR_W (16)
    ) dut (
        .iCLOCK      (clk),
        .iRESET_SYNC (rst),
        .iIF_REQ     (req),
        .oIF_BUSY    (busy),
        .iIF_CHAR    (ch),
        .iIF_CX      (cx),
        .iIF_CY      (cy),
        .iIF_FG      (fg),
        .iIF_BG      (bg),
        .oIF_DONE    (done),
        .oIF_ERR     (err),
        .oVRAM_REQ   (vreq),
        .iVRAM_BUSY  (vbusy),
        .oVRAM_ADDR  (vaddr),
        .oVRAM_DATA  (vdata)
    );

    typedef struct {
        int          addr;
        logic [15:0] data;
    } wr_t;

    int          passed = 0;
    int          total  = 0;
    wr_t         exp_q[$];
    int          n_writes;
    int          first_addr;
    int          last_addr;
    logic [15:0] seen [int];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Font rows as drawn on screen, top row first, MSB = leftmost pixel.
    function automatic logic [7:0] font_row(input logic [6:0] c, input int r);
        logic [7:0] g [14];
        g = '{default: 8'h00};
        case (c)
            7'h2D: g[7] = 8'h7E;
            7'h30: g = '{8'h00,8'h00,8'h3C,8'h66,8'h6E,8'h76,8'h66,8'h66,8'h66,8'h3C,8'h00,8'h00,8'h00,8'h00};
            7'h41: g = '{8'h00,8'h00,8'h18,8'h3C,8'h66,8'h66,8'h7E,8'h66,8'h66,8'h66,8'h66,8'h00,8'h00,8'h00};
            default: ;
        endcase
        return g[r];
    endfunction

    function automatic bit pix_on(input logic [6:0] c, input int r, input int col);
        logic [7:0] rowv;
        rowv = font_row(c, r);
        return rowv[7 - col];
    endfunction

    task automatic push_expect(input logic [6:0] c, input int x, input int y,
                               input logic [15:0] f, input logic [15:0] b);
        wr_t w;
        for (int r = 0; r < 14; r++)
            for (int col = 0; col < 8; col++) begin
                w.addr = (y * 14 + r) * 640 + x * 8 + col;
                w.data = pix_on(c, r, col) ? f : b;
                if (!TRANSP || pix_on(c, r, col)) exp_q.push_back(w);
            end
    endtask

    // Interval (counted from the command interval) in which DONE must show.
    // With toggling backpressure, VRAM is busy in every even interval.
    function automatic int model_done(input logic [6:0] c, input bit toggle);
        int t = 2;
        for (int p = 0; p < 112; p++) begin
            if (TRANSP && !pix_on(c, p / 8, p % 8)) t++;
            else begin
                if (toggle && (t % 2 == 0)) t++;
                t++;
            end
        end
        return t;
    endfunction

    function automatic longint seen_at(input int a);
        return seen.exists(a) ? longint'(seen[a]) : -1;
    endfunction

    // Write monitor: every accepted write must match the model, in order;
    // a stalled write must be held unchanged into the next cycle.
    initial begin
        bit          stall_prev = 1'b0;
        logic [18:0] pa = '0;
        logic [15:0] pd = '0;
        wr_t         e;
        forever begin
            @(negedge clk);
            if (stall_prev) begin
                check("hold_req", vreq, 1);
                check("hold_addr", vaddr, pa);
                check("hold_data", vdata, pd);
            end
            stall_prev = vreq && vbusy && !rst;
            pa = vaddr;
            pd = vdata;
            if (vreq && !vbusy) begin
                if (exp_q.size() == 0) check("spurious_write", vaddr, -1);
                else begin
                    e = exp_q.pop_front();
                    check("write_addr", vaddr, e.addr);
                    check("write_data", vdata, e.data);
                end
                if (n_writes == 0) first_addr = int'(vaddr);
                last_addr = int'(vaddr);
                seen[int'(vaddr)] = vdata;
                n_writes++;
            end
        end
    end

    task automatic run_cmd(input logic [6:0] c, input logic [6:0] x, input logic [5:0] y,
                           input logic [15:0] f, input logic [15:0] b,
                           input bit toggle, input bit hold_bad, output int done_k);
        bit ok;
        bit saw_err;
        int n_exp;
        ok       = (x < 80) && (y < 34);
        saw_err  = 1'b0;
        done_k   = -1;
        n_writes = 0;
        seen.delete();
        exp_q.delete();
        if (ok) push_expect(c, int'(x), int'(y), f, b);
        n_exp = exp_q.size();
        @(posedge clk); #1;
        req = 1'b1; ch = c; cx = x; cy = y; fg = f; bg = b; vbusy = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (k == 0) check("idle_busy", busy, 0);
            if (k == 1) begin
                check("busy_after_accept", busy, ok);
                check("err_pulse", err, !ok);
            end
            if (k >= 2 && err) saw_err = 1'b1;
            if (done) begin
                done_k = k;
                break;
            end
            if (!ok && k == 20) break;
            @(posedge clk); #1;
            req = hold_bad && (k + 1 < 30);
            cx  = hold_bad ? 7'd80 : x;
            vbusy = toggle && ((k + 1) % 2 == 0);
        end
        check("no_late_err", saw_err, 0);
        check("write_count", n_writes, n_exp);
        check("queue_drained", exp_q.size(), 0);
        if (ok) begin
            check("done_cycle", done_k, model_done(c, toggle));
            check("idle_at_done", busy, 0);
            @(posedge clk); #1;
            vbusy = 1'b0;
            @(negedge clk);
            check("done_one_cycle", done, 0);
        end else begin
            check("never_busy", busy, 0);
            check("no_done", done_k, -1);
        end
    endtask

    initial begin
        int dk;
        bit saw_done;
        rst = 1'b1; req = 1'b0; ch = '0; cx = '0; cy = '0;
        fg = '0; bg = '0; vbusy = 1'b0; n_writes = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_vreq", vreq, 0);
        check("rst_vaddr", vaddr, 0);
        check("rst_vdata", vdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 'A' at the origin, no backpressure.
        run_cmd(7'h41, 7'd0, 6'd0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, dk);
        check("A_done_N114", dk, 114);
        check("A_1283", seen_at(1283), 16'hFFFF);
`ifndef GCI_STD_DISPLAY_CHAR_TRANSPARENT_EN
        check("A_1282", seen_at(1282), 16'h0000);
        check("A_first", first_addr, 0);
        check("A_last", last_addr, 8327);

        // '0' in the bottom-right cell.
        run_cmd(7'h30, 7'd79, 6'd33, 16'h07E0, 16'h001F, 1'b0, 1'b0, dk);
        check("zero_first", first_addr, 296312);
        check("zero_last", last_addr, 304639);

        // 'A' with VRAM busy every other cycle.
        run_cmd(7'h41, 7'd0, 6'd0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, dk);
        check("A_bp_done", dk, 226);
        check("A_bp_writes", n_writes, 112);

        // Code below 0x20 renders as background only.
        run_cmd(7'h05, 7'd3, 6'd5, 16'h1234, 16'hABCD, 1'b0, 1'b0, dk);
        check("ctrl_bg", seen_at(5 * 14 * 640 + 24), 16'hABCD);
`else
        // Space: nothing written, timing unchanged.
        run_cmd(7'h20, 7'd0, 6'd0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, dk);
        check("space_writes", n_writes, 0);
        check("space_done", dk, 114);

        // '-': six foreground pixels on row 7.
        run_cmd(7'h2D, 7'd0, 6'd0, 16'hF00F, 16'h0000, 1'b0, 1'b0, dk);
        check("dash_writes", n_writes, 6);
        check("dash_first", first_addr, 7 * 640 + 1);
        check("dash_last", last_addr, 7 * 640 + 6);
        check("dash_col6", seen_at(7 * 640 + 6), 16'hF00F);

        run_cmd(7'h41, 7'd0, 6'd0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, dk);
`endif

        // Out-of-range positions are dropped.
        run_cmd(7'h41, 7'd80, 6'd0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, dk);
        run_cmd(7'h41, 7'd0, 6'd34, 16'hFFFF, 16'h0000, 1'b0, 1'b0, dk);

        // Reset while pixel 40 is on the bus.
        n_writes = 0;
        exp_q.delete();
        push_expect(7'h41, 2, 1, 16'hFFFF, 16'h0000);
        @(posedge clk); #1;
        req = 1'b1; ch = 7'h41; cx = 7'd2; cy = 6'd1; fg = 16'hFFFF; bg = 16'h0000;
        @(posedge clk); #1;
        req = 1'b0;
        for (int k = 0; k < 200 && !(n_writes == 40 || (TRANSP && n_writes > 0)); k++)
            @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_vreq", vreq, 0);
        check("rst_mid_busy", busy, 0);
        saw_done = done;
        for (int k = 0; k < 130; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("rst_mid_no_done", saw_done, 0);

        run_cmd(7'h41, 7'd0, 6'd0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, dk);
        check("after_rst_done", dk, 114);
        check("after_rst_first", first_addr, TRANSP ? 2 * 640 + 3 : 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
